// File: rtl/ccff_shadow_mem_chain_pkg.sv
// ccff_mem_pkg: FSM state encoding and chain sizing for the shadow config chain.
// CCFF_MEM_PARITY_EN adds one even-parity stage to every chain.
package ccff_mem_pkg;
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_LOADING = 2'd1;
    localparam logic [1:0] ST_LOADED  = 2'd2;
    localparam logic [1:0] ST_ACTIVE  = 2'd3;
`ifdef CCFF_MEM_PARITY_EN
    localparam int PARITY_STAGES = 1;
`else
    localparam int PARITY_STAGES = 0;
`endif
    function automatic int cnt_width(input int l);
        return $clog2(l + 1);
    endfunction
endpackage

// File: rtl/ccff_shadow_mem_chain_if.sv
// ccff_shadow_mem_chain_if: serial config port, committed outputs and status flags of one chain block.
interface ccff_shadow_mem_chain_if #(parameter int NUM_BITS = 5);
    logic                ccff_head;
    logic                ccff_shift_en;
    logic                ccff_commit;
    logic                ccff_tail;
    logic [NUM_BITS-1:0] mem_out;
    logic [NUM_BITS-1:0] mem_outb;
    logic                cfg_loaded;
    logic                cfg_ovf;
    logic                cfg_err;
    modport master(
        output ccff_head, ccff_shift_en, ccff_commit,
        input  ccff_tail, mem_out, mem_outb, cfg_loaded, cfg_ovf, cfg_err
    );
    modport slave(
        input  ccff_head, ccff_shift_en, ccff_commit,
        output ccff_tail, mem_out, mem_outb, cfg_loaded, cfg_ovf, cfg_err
    );
endinterface

// File: rtl/ccff_shadow_mem_chain_shift_chain.sv
// ccff_shift_chain: L-stage serial shift register with a saturating shift counter.
module ccff_shift_chain
    import ccff_mem_pkg::*;
#(
    parameter int L  = 5,
    parameter int CW = cnt_width(L)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          head,
    input  logic          shift_en,
    input  logic          clr,
    output logic [L-1:0]  sreg,
    output logic [CW-1:0] cnt,
    output logic          loaded,
    output logic          tail
);
    logic [L:0] ext;
    assign ext    = {sreg, head};
    assign loaded = cnt == CW'(L);
    assign tail   = sreg[L-1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else begin
            sreg <= shift_en ? ext[L-1:0] : sreg;
            cnt  <= clr ? CW'(shift_en) : (shift_en && !loaded) ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: rtl/ccff_shadow_mem_chain.sv
// ccff_shadow_mem_chain: double-buffered configuration chain with load FSM and status flags.
// CCFF_MEM_PARITY_EN adds a parity stage and rejects commits of words with odd parity.
module ccff_shadow_mem_chain
    import ccff_mem_pkg::*;
#(
    parameter int NUM_BITS = 5
) (
    input logic                    prog_clk,
    input logic                    prog_reset,
    ccff_shadow_mem_chain_if.slave bus
);
    localparam int L  = NUM_BITS + PARITY_STAGES;
    localparam int CW = cnt_width(L);
    logic [L-1:0]        sreg;
    logic [CW-1:0]       cnt;
    logic [1:0]          state, state_nxt;
    logic [NUM_BITS-1:0] mem_q;
    logic                ovf_q, err_q;
    logic                shift, in_loaded, clr, accept, last, par_ok;
    ccff_shift_chain #(.L(L), .CW(CW)) u_chain (
        .clk      (prog_clk),
        .rst      (prog_reset),
        .head     (bus.ccff_head),
        .shift_en (shift),
        .clr      (clr),
        .sreg     (sreg),
        .cnt      (cnt),
        .loaded   (bus.cfg_loaded),
        .tail     (bus.ccff_tail)
    );
`ifdef CCFF_MEM_PARITY_EN
    assign par_ok = ~^sreg;
`else
    assign par_ok = 1'b1;
`endif
    assign shift     = bus.ccff_shift_en;
    assign in_loaded = state == ST_LOADED;
    assign clr       = bus.ccff_commit && in_loaded;
    assign accept    = clr && par_ok;
    assign last      = cnt >= CW'(L - 1);
    // A commit in LOADED restarts the count, so a same-edge shift lands as the first bit of a new load.
    assign state_nxt = clr ? (shift ? (L == 1 ? ST_LOADED : ST_LOADING) : accept ? ST_ACTIVE : ST_LOADING)
                     : shift ? (last ? ST_LOADED : ST_LOADING) : state;
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state <= ST_EMPTY;
            mem_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            mem_q <= accept ? sreg[NUM_BITS-1:0] : mem_q;
            ovf_q <= accept ? 1'b0 : ovf_q || (shift && in_loaded);
            err_q <= err_q || (bus.ccff_commit && !accept);
        end
    end
    assign bus.mem_out  = mem_q;
    assign bus.mem_outb = ~mem_q;
    assign bus.cfg_ovf  = ovf_q;
    assign bus.cfg_err  = err_q;
endmodule

// File: tb/tb_ccff_shadow_mem_chain.sv
// tb_ccff_shadow_mem_chain: directed vectors with a queued scoreboard checked after each programming edge.
module tb_ccff_shadow_mem_chain;
    logic clk = 1'b0;
    logic prog_reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    typedef struct {
        string      tag;
        logic [4:0] m;
        logic       ld, ov, er, tl, ct;
    } exp_t;
    exp_t sb[$];
    ccff_shadow_mem_chain_if #(.NUM_BITS(5)) bus();
    ccff_shadow_mem_chain #(.NUM_BITS(5)) dut (
        .prog_clk   (clk),
        .prog_reset (prog_reset),
        .bus        (bus)
    );
    always #5 clk = ~clk;
    task automatic push(input string tag, input logic [4:0] m, input logic ld, ov, er, tl, ct);
        exp_t e;
        e.tag = tag; e.m = m; e.ld = ld; e.ov = ov; e.er = er; e.tl = tl; e.ct = ct;
        sb.push_back(e);
    endtask
    task automatic step(input string tag, input logic h, s, c, input logic [4:0] m,
                        input logic ld, ov, er, tl, ct);
        @(negedge clk);
        bus.ccff_head = h; bus.ccff_shift_en = s; bus.ccff_commit = c;
        push(tag, m, ld, ov, er, tl, ct);
    endtask
    task automatic rst_pulse(input string tag);
        @(negedge clk);
        prog_reset = 1'b1;
        bus.ccff_head = 1'b0; bus.ccff_shift_en = 1'b0; bus.ccff_commit = 1'b0;
        push(tag, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2 prog_reset = 1'b0;
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (bus.mem_out !== e.m || bus.mem_outb !== ~e.m || bus.cfg_loaded !== e.ld ||
                    bus.cfg_ovf !== e.ov || bus.cfg_err !== e.er || (e.ct && bus.ccff_tail !== e.tl)) begin
                    n_err++;
                    $display("FAIL %s: got mem=%b mb=%b ld=%b ovf=%b err=%b tail=%b, want mem=%b mb=%b ld=%b ovf=%b err=%b tail=%b(chk=%b)",
                             e.tag, bus.mem_out, bus.mem_outb, bus.cfg_loaded, bus.cfg_ovf, bus.cfg_err,
                             bus.ccff_tail, e.m, ~e.m, e.ld, e.ov, e.er, e.tl, e.ct);
                end
            end
        end
    end
    initial begin
        bus.ccff_head = 1'b0; bus.ccff_shift_en = 1'b0; bus.ccff_commit = 1'b0;
        rst_pulse("reset");
`ifdef CCFF_MEM_PARITY_EN
        step("p_par",  1, 1, 0, 5'b00000, 0, 0, 0, 0, 0);
        step("p_d1",   1, 1, 0, 5'b00000, 0, 0, 0, 0, 0);
        step("p_d2",   0, 1, 0, 5'b00000, 0, 0, 0, 0, 0);
        step("p_d3",   1, 1, 0, 5'b00000, 0, 0, 0, 0, 0);
        step("p_d4",   1, 1, 0, 5'b00000, 0, 0, 0, 0, 0);
        step("p_d5",   0, 1, 0, 5'b00000, 1, 0, 0, 0, 0);
        step("p_cmt",  0, 0, 1, 5'b10110, 0, 0, 0, 0, 0);
        step("q_par",  0, 1, 0, 5'b10110, 0, 0, 0, 0, 0);
        step("q_d1",   1, 1, 0, 5'b10110, 0, 0, 0, 0, 0);
        step("q_d2",   0, 1, 0, 5'b10110, 0, 0, 0, 0, 0);
        step("q_d3",   1, 1, 0, 5'b10110, 0, 0, 0, 0, 0);
        step("q_d4",   1, 1, 0, 5'b10110, 0, 0, 0, 0, 0);
        step("q_d5",   0, 1, 0, 5'b10110, 1, 0, 0, 0, 0);
        step("q_rej",  0, 0, 1, 5'b10110, 0, 0, 1, 0, 0);
        step("q_idle", 0, 0, 0, 5'b10110, 0, 0, 1, 0, 0);
`else
        step("a1",     1, 1, 0, 5'b00000, 0, 0, 0, 0, 1);
        step("a2",     0, 1, 0, 5'b00000, 0, 0, 0, 0, 1);
        step("a3",     1, 1, 0, 5'b00000, 0, 0, 0, 0, 1);
        step("a4",     1, 1, 0, 5'b00000, 0, 0, 0, 0, 1);
        step("a5",     0, 1, 0, 5'b00000, 1, 0, 0, 1, 1);
        step("a_cmt",  0, 0, 1, 5'b10110, 0, 0, 0, 1, 1);
        step("b1",     1, 1, 0, 5'b10110, 0, 0, 0, 0, 1);
        step("b2",     1, 1, 0, 5'b10110, 0, 0, 0, 1, 1);
        step("b3",     1, 1, 0, 5'b10110, 0, 0, 0, 1, 1);
        step("b_early",0, 0, 1, 5'b10110, 0, 0, 1, 1, 1);
        step("b4",     0, 1, 0, 5'b10110, 0, 0, 1, 0, 1);
        step("b5",     0, 1, 0, 5'b10110, 1, 0, 1, 1, 1);
        step("b_cmt",  0, 0, 1, 5'b11100, 0, 0, 1, 1, 1);
        step("c1",     1, 1, 0, 5'b11100, 0, 0, 1, 1, 1);
        step("c2",     0, 1, 0, 5'b11100, 0, 0, 1, 1, 1);
        step("c3",     0, 1, 0, 5'b11100, 0, 0, 1, 0, 1);
        step("c4",     1, 1, 0, 5'b11100, 0, 0, 1, 0, 1);
        step("c5",     1, 1, 0, 5'b11100, 1, 0, 1, 1, 1);
        step("c6",     0, 1, 0, 5'b11100, 1, 1, 1, 0, 1);
        step("c7",     1, 1, 0, 5'b11100, 1, 1, 1, 0, 1);
        step("c_cmt",  0, 0, 1, 5'b01101, 0, 0, 1, 0, 1);
        step("m1",     1, 1, 0, 5'b01101, 0, 0, 1, 1, 1);
        step("m2",     1, 1, 0, 5'b01101, 0, 0, 1, 1, 1);
        rst_pulse("reset_mid");
        step("d1",     1, 1, 0, 5'b00000, 0, 0, 0, 0, 1);
        step("d2",     1, 1, 0, 5'b00000, 0, 0, 0, 0, 1);
        step("d3",     0, 1, 0, 5'b00000, 0, 0, 0, 0, 1);
        step("d4",     0, 1, 0, 5'b00000, 0, 0, 0, 0, 1);
        step("d5",     1, 1, 0, 5'b00000, 1, 0, 0, 1, 1);
        step("d_sc",   0, 1, 1, 5'b11001, 0, 0, 0, 1, 1);
        step("d6",     1, 1, 0, 5'b11001, 0, 0, 0, 0, 1);
        step("d7",     0, 1, 0, 5'b11001, 0, 0, 0, 0, 1);
        step("d8",     1, 1, 0, 5'b11001, 0, 0, 0, 1, 1);
        step("d9",     0, 1, 0, 5'b11001, 1, 0, 0, 0, 1);
        step("d_cmt",  0, 0, 1, 5'b01010, 0, 0, 0, 0, 1);
        rst_pulse("reset_e");
        step("e_cmt",  0, 0, 1, 5'b00000, 0, 0, 1, 0, 1);
        step("e_idle", 0, 0, 0, 5'b00000, 0, 0, 1, 0, 1);
`endif
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
